// File: rtl/in_polygon_seq.sv
// rtl/in_polygon_seq.sv - sequential LANES-wide point-in-polygon tester
module in_polygon_seq #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int LANES            = 4,
  localparam int NB              = $clog2(MAX_NUM_VERTICES + 1)
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic                                         req_valid_in,
  output logic                                         req_ready_out,
  input  logic signed [WORLD_BITS-1:0]                 x_in,
  input  logic signed [WORLD_BITS-1:0]                 y_in,
  input  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  poly_xs_in,
  input  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0]  poly_ys_in,
  input  logic [NB-1:0]                                num_points_in,
  input  logic                                         nonzero_mode_in,
  output logic                                         res_valid_out,
  input  logic                                         res_ready_in,
  output logic                                         inside_out,
  output logic signed [NB:0]                           winding_out,
  output logic                                         degenerate_out
);

  localparam int WW = NB + 1;
  localparam int EW = NB + 1;
  localparam int IW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
  localparam int DW = WORLD_BITS + 1;
  localparam int PW = 2 * WORLD_BITS + 3;
  localparam logic [NB-1:0] MAX_N   = NB'(MAX_NUM_VERTICES);
  localparam logic [EW-1:0] LANES_E = EW'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] xs_q, ys_q;
  logic signed [WORLD_BITS-1:0] px_q, py_q;
  logic [NB-1:0]                n_q;
  logic                         mode_q;
  logic                         degen_q;
  logic [EW-1:0]                e_q;
  logic signed [WW-1:0]         acc_q;
  logic signed [1:0]            lane_c_q [LANES];

  logic                         accept;
  logic                         degen_in;
  logic                         run_last;
  logic [EW-1:0]                n_ext;
  logic signed [WW-1:0]         lane_sum;

  logic [EW-1:0]                lane_k     [LANES];
  logic                         lane_en    [LANES];
  logic [IW-1:0]                lane_i     [LANES];
  logic [IW-1:0]                lane_j     [LANES];
  logic signed [WORLD_BITS-1:0] lane_xi    [LANES];
  logic signed [WORLD_BITS-1:0] lane_yi    [LANES];
  logic signed [WORLD_BITS-1:0] lane_xj    [LANES];
  logic signed [WORLD_BITS-1:0] lane_yj    [LANES];
  logic signed [DW-1:0]         lane_dxe   [LANES];
  logic signed [DW-1:0]         lane_dye   [LANES];
  logic signed [DW-1:0]         lane_dxp   [LANES];
  logic signed [DW-1:0]         lane_dyp   [LANES];
  logic signed [PW-1:0]         lane_cross [LANES];
  logic                         lane_up    [LANES];
  logic                         lane_down  [LANES];
  logic signed [1:0]            lane_c     [LANES];

  assign accept   = (state_q == IDLE) && req_valid_in;
  assign degen_in = (num_points_in < NB'(3)) || (num_points_in > MAX_N);
  assign n_ext    = {1'b0, n_q};
  assign run_last = (e_q + LANES_E) >= n_ext;

  // Lanes past the last edge are forced to vertex 0 so indexing stays in range.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_k[l]     = e_q + EW'(l);
      lane_en[l]    = lane_k[l] < n_ext;
      lane_i[l]     = lane_en[l] ? lane_k[l][IW-1:0] : '0;
      lane_j[l]     = (lane_en[l] && ((lane_k[l] + EW'(1)) != n_ext)) ? (lane_i[l] + IW'(1)) : '0;
      lane_xi[l]    = $signed(xs_q[lane_i[l]]);
      lane_yi[l]    = $signed(ys_q[lane_i[l]]);
      lane_xj[l]    = $signed(xs_q[lane_j[l]]);
      lane_yj[l]    = $signed(ys_q[lane_j[l]]);
      lane_dxe[l]   = DW'(lane_xj[l]) - DW'(lane_xi[l]);
      lane_dye[l]   = DW'(lane_yj[l]) - DW'(lane_yi[l]);
      lane_dxp[l]   = DW'(px_q) - DW'(lane_xi[l]);
      lane_dyp[l]   = DW'(py_q) - DW'(lane_yi[l]);
      lane_cross[l] = PW'(lane_dxe[l]) * PW'(lane_dyp[l]) - PW'(lane_dxp[l]) * PW'(lane_dye[l]);
      lane_up[l]    = (lane_yi[l] <= py_q) && (py_q < lane_yj[l]);
      lane_down[l]  = (lane_yj[l] <= py_q) && (py_q < lane_yi[l]);
      lane_c[l]     = 2'sd0;
      if (lane_en[l] && lane_up[l] && (lane_cross[l] > 0))
        lane_c[l] = 2'sd1;
      else if (lane_en[l] && lane_down[l] && (lane_cross[l] < 0))
        lane_c[l] = -2'sd1;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++)
      lane_sum = lane_sum + WW'(lane_c_q[l]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    req_ready_out  = 1'b0;
    res_valid_out  = 1'b0;
    inside_out     = 1'b0;
    winding_out    = '0;
    degenerate_out = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in)
          state_d = degen_in ? DONE : RUN;
      end
      RUN: begin
        if (run_last)
          state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        res_valid_out  = 1'b1;
        winding_out    = acc_q;
        degenerate_out = degen_q;
        inside_out     = mode_q ? (acc_q != '0) : acc_q[0];
        if (res_ready_in)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Query operands need no reset: they are always written on accept before use.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      xs_q <= poly_xs_in;
      ys_q <= poly_ys_in;
      px_q <= x_in;
      py_q <= y_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_q     <= '0;
      mode_q  <= 1'b0;
      degen_q <= 1'b0;
      e_q     <= '0;
      acc_q   <= '0;
      for (int l = 0; l < LANES; l++)
        lane_c_q[l] <= 2'sd0;
    end else if (accept) begin
      n_q     <= num_points_in;
      mode_q  <= nonzero_mode_in;
      degen_q <= degen_in;
      e_q     <= '0;
      acc_q   <= '0;
      for (int l = 0; l < LANES; l++)
        lane_c_q[l] <= 2'sd0;
    end else if (state_q == RUN) begin
      e_q   <= e_q + LANES_E;
      acc_q <= acc_q + lane_sum;
      for (int l = 0; l < LANES; l++)
        lane_c_q[l] <= lane_c[l];
    end else if (state_q == DRAIN) begin
      acc_q <= acc_q + lane_sum;
      for (int l = 0; l < LANES; l++)
        lane_c_q[l] <= 2'sd0;
    end
  end

endmodule

// File: tb/tb_in_polygon_seq.sv
// tb/tb_in_polygon_seq.sv - directed self-checking bench for in_polygon_seq
module tb_in_polygon_seq;

  localparam int WB = 32;
  localparam int MV = 32;
  localparam int NB = 6;

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic                    req_valid_in;
  logic                    req_ready_out;
  logic signed [WB-1:0]    x_in, y_in;
  logic [MV-1:0][WB-1:0]   poly_xs_in, poly_ys_in;
  logic [NB-1:0]           num_points_in;
  logic                    nonzero_mode_in;
  logic                    res_valid_out;
  logic                    res_ready_in;
  logic                    inside_out;
  logic signed [NB:0]      winding_out;
  logic                    degenerate_out;

  int checks = 0;
  int passed = 0;

  always #5 clk_in = ~clk_in;

  in_polygon_seq #(.WORLD_BITS(WB), .MAX_NUM_VERTICES(MV), .LANES(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .x_in(x_in), .y_in(y_in),
    .poly_xs_in(poly_xs_in), .poly_ys_in(poly_ys_in),
    .num_points_in(num_points_in), .nonzero_mode_in(nonzero_mode_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .inside_out(inside_out), .winding_out(winding_out),
    .degenerate_out(degenerate_out)
  );

  task automatic set_square();
    poly_xs_in = '0;
    poly_ys_in = '0;
    poly_xs_in[0] = 0;   poly_ys_in[0] = 0;
    poly_xs_in[1] = 10;  poly_ys_in[1] = 0;
    poly_xs_in[2] = 10;  poly_ys_in[2] = 10;
    poly_xs_in[3] = 0;   poly_ys_in[3] = 10;
  endtask

  task automatic set_pentagram();
    poly_xs_in = '0;
    poly_ys_in = '0;
    poly_xs_in[0] = 0;    poly_ys_in[0] = 10;
    poly_xs_in[1] = 6;    poly_ys_in[1] = -8;
    poly_xs_in[2] = -10;  poly_ys_in[2] = 4;
    poly_xs_in[3] = 10;   poly_ys_in[3] = 4;
    poly_xs_in[4] = -6;   poly_ys_in[4] = -8;
  endtask

  // Drives one query from #1 after an edge and returns once res_valid is seen (or bound expires).
  task automatic run_query(input int px, input int py, input int n, input bit mode,
                           output int lat, output logic ins,
                           output logic signed [NB:0] wnd, output logic deg);
    int guard;
    x_in = px;
    y_in = py;
    num_points_in = NB'(n);
    nonzero_mode_in = mode;
    req_valid_in = 1'b1;
    guard = 0;
    while (!req_ready_out && guard < 50) begin
      @(posedge clk_in); #1;
      guard++;
    end
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
    x_in = 32'sd12345;
    y_in = -32'sd777;
    num_points_in = '0;
    nonzero_mode_in = ~mode;
    poly_xs_in = '1;
    lat = 1;
    while (!res_valid_out && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
    end
    ins = inside_out;
    wnd = winding_out;
    deg = degenerate_out;
  endtask

  task automatic finish_result();
    res_ready_in = 1'b1;
    @(posedge clk_in); #1;
    res_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    req_valid_in = 1'b0;
    res_ready_in = 1'b0;
    x_in = '0; y_in = '0;
    poly_xs_in = '0; poly_ys_in = '0;
    num_points_in = '0;
    nonzero_mode_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (req_ready_out !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready_out); else passed++;
    checks++; if (res_valid_out !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid_out); else passed++;
    checks++; if (inside_out !== 1'b0) $display("FAIL reset_inside got %b want 0", inside_out); else passed++;
    checks++; if (winding_out !== 7'sd0) $display("FAIL reset_winding got %0d want 0", winding_out); else passed++;
    checks++; if (degenerate_out !== 1'b0) $display("FAIL reset_degenerate got %b want 0", degenerate_out); else passed++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_square();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    int pxs [4] = '{5, 15, 0, 10};
    logic exp_in [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic signed [NB:0] exp_w [4] = '{7'sd1, 7'sd0, 7'sd1, 7'sd0};
    for (int t = 0; t < 4; t++) begin
      set_square();
      run_query(pxs[t], 5, 4, 1'b0, lat, ins, wnd, deg);
      checks++; if (ins !== exp_in[t]) $display("FAIL square_inside x=%0d got %b want %b", pxs[t], ins, exp_in[t]); else passed++;
      checks++; if (wnd !== exp_w[t]) $display("FAIL square_winding x=%0d got %0d want %0d", pxs[t], wnd, exp_w[t]); else passed++;
      checks++; if (lat !== 3) $display("FAIL square_latency x=%0d got %0d want 3", pxs[t], lat); else passed++;
      checks++; if (deg !== 1'b0) $display("FAIL square_degenerate x=%0d got %b want 0", pxs[t], deg); else passed++;
      finish_result();
    end
  endtask

  task automatic test_pentagram();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    for (int m = 0; m < 2; m++) begin
      set_pentagram();
      run_query(0, 0, 5, m[0], lat, ins, wnd, deg);
      checks++; if (ins !== m[0]) $display("FAIL star_inside mode=%0d got %b want %b", m, ins, m[0]); else passed++;
      checks++; if (wnd !== -7'sd2) $display("FAIL star_winding mode=%0d got %0d want -2", m, wnd); else passed++;
      checks++; if (lat !== 4) $display("FAIL star_latency mode=%0d got %0d want 4", m, lat); else passed++;
      finish_result();
    end
  endtask

  task automatic test_degenerate();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    int ns [3] = '{2, 0, 33};
    for (int t = 0; t < 3; t++) begin
      set_square();
      run_query(5, 5, ns[t], 1'b1, lat, ins, wnd, deg);
      checks++; if (deg !== 1'b1) $display("FAIL degen_flag n=%0d got %b want 1", ns[t], deg); else passed++;
      checks++; if (ins !== 1'b0) $display("FAIL degen_inside n=%0d got %b want 0", ns[t], ins); else passed++;
      checks++; if (wnd !== 7'sd0) $display("FAIL degen_winding n=%0d got %0d want 0", ns[t], wnd); else passed++;
      checks++; if (lat !== 1) $display("FAIL degen_latency n=%0d got %0d want 1", ns[t], lat); else passed++;
      finish_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    set_square();
    run_query(5, 5, 4, 1'b0, lat, ins, wnd, deg);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #1;
      checks++;
      if (res_valid_out !== 1'b1 || inside_out !== 1'b1 || winding_out !== 7'sd1 || req_ready_out !== 1'b0)
        $display("FAIL hold_cycle%0d got v=%b in=%b w=%0d rdy=%b want v=1 in=1 w=1 rdy=0",
                 c, res_valid_out, inside_out, winding_out, req_ready_out);
      else passed++;
    end
    finish_result();
    checks++; if (req_ready_out !== 1'b1) $display("FAIL release_ready got %b want 1", req_ready_out); else passed++;
    checks++; if (res_valid_out !== 1'b0) $display("FAIL release_valid got %b want 0", res_valid_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    set_square();
    run_query(15, 5, 4, 1'b0, lat, ins, wnd, deg);
    checks++; if (ins !== 1'b0 || wnd !== 7'sd0) $display("FAIL b2b_first got in=%b w=%0d want in=0 w=0", ins, wnd); else passed++;
    finish_result();
    set_pentagram();
    run_query(0, 0, 5, 1'b1, lat, ins, wnd, deg);
    checks++; if (ins !== 1'b1 || wnd !== -7'sd2) $display("FAIL b2b_second got in=%b w=%0d want in=1 w=-2", ins, wnd); else passed++;
    checks++; if (lat !== 4) $display("FAIL b2b_second_latency got %0d want 4", lat); else passed++;
    finish_result();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic ins, deg; logic signed [NB:0] wnd;
    set_pentagram();
    x_in = 0; y_in = 0;
    num_points_in = 6'd5;
    nonzero_mode_in = 1'b1;
    req_valid_in = 1'b1;
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    checks++; if (res_valid_out !== 1'b0) $display("FAIL midrst_valid got %b want 0", res_valid_out); else passed++;
    checks++; if (req_ready_out !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready_out); else passed++;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (req_ready_out !== 1'b1) $display("FAIL postrst_ready got %b want 1", req_ready_out); else passed++;
    set_square();
    run_query(5, 5, 4, 1'b0, lat, ins, wnd, deg);
    checks++; if (ins !== 1'b1 || wnd !== 7'sd1) $display("FAIL postrst_square got in=%b w=%0d want in=1 w=1", ins, wnd); else passed++;
    checks++; if (lat !== 3) $display("FAIL postrst_latency got %0d want 3", lat); else passed++;
    finish_result();
  endtask

  initial begin
    test_reset();
    test_square();
    test_pentagram();
    test_degenerate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
